// File: rtl/buzzer_padrao_if.sv
// Alarm request / buzzer status bundle for buzzer_padrao.
// master = alarm source (drives liga/desliga), slave = buzzer_padrao.
interface buzzer_padrao_if #(
    parameter int CANAIS = 4
) ();
    localparam int LARGURA_CANAL = (CANAIS > 1) ? $clog2(CANAIS) : 1;

    logic [CANAIS-1:0]        liga;
    logic [CANAIS-1:0]        desliga;
    logic                     sinal;
    logic [CANAIS-1:0]        ativo;
    logic [LARGURA_CANAL-1:0] canal_atual;
    logic                     ocupado;

    modport master (
        output liga,
        output desliga,
        input  sinal,
        input  ativo,
        input  canal_atual,
        input  ocupado
    );

    modport slave (
        input  liga,
        input  desliga,
        output sinal,
        output ativo,
        output canal_atual,
        output ocupado
    );
endinterface

// File: rtl/buzzer_padrao.sv
// Multi-channel alarm buzzer: per-channel arm flags, fixed-priority arbiter and beep-pattern FSM.
// Optional macro BUZZER_REPETICOES_EN auto-disarms a channel after MAX_BIPES completed on-phases.
module buzzer_padrao #(
    parameter int CANAIS       = 4,
    parameter int PERIODO_BASE = 1000,
    parameter int MAX_BIPES    = 3
) (
    input  logic           clock,
    input  logic           zera_n,
    buzzer_padrao_if.slave bus
);
    localparam int LARGURA_CONT  = $clog2(PERIODO_BASE * CANAIS + 1);
    localparam int LARGURA_CANAL = (CANAIS > 1) ? $clog2(CANAIS) : 1;

    localparam logic [LARGURA_CONT-1:0]  CONT_ZERO  = LARGURA_CONT'(0);
    localparam logic [LARGURA_CONT-1:0]  CONT_UM    = LARGURA_CONT'(1);
    localparam logic [LARGURA_CONT-1:0]  BASE       = LARGURA_CONT'(PERIODO_BASE);
    localparam logic [LARGURA_CONT-1:0]  LIMITE_ON  = LARGURA_CONT'(PERIODO_BASE - 1);
    localparam logic [LARGURA_CANAL-1:0] CANAL_ZERO = LARGURA_CANAL'(0);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LIGADO    = 2'd1,
        DESLIGADO = 2'd2
    } estado_t;

    logic [CANAIS-1:0]        ativo_r;
    logic [CANAIS-1:0]        ativo_prox_s;
    logic [CANAIS-1:0]        desarme_s;
    logic                     ocupado_r;
    logic                     sinal_r;
    logic                     sinal_prox_s;
    estado_t                  estado_r;
    estado_t                  estado_prox_s;
    logic [LARGURA_CONT-1:0]  cont_r;
    logic [LARGURA_CONT-1:0]  cont_prox_s;
    logic [LARGURA_CONT-1:0]  limite_off_s;
    logic [LARGURA_CANAL-1:0] canal_r;
    logic [LARGURA_CANAL-1:0] canal_prox_s;
    logic [LARGURA_CANAL-1:0] sel_s;
    logic                     algum_s;
    logic                     conclusao_s;
    logic                     preempcao_s;

    // Arbiter: lowest armed index wins, taken from the registered flags.
    always_comb begin
        sel_s = CANAL_ZERO;
        for (int i = CANAIS - 1; i >= 0; i--) begin
            sel_s = ativo_r[i] ? LARGURA_CANAL'(i) : sel_s;
        end
    end

    assign algum_s      = |ativo_r;
    assign limite_off_s = (BASE * LARGURA_CONT'(canal_r)) - CONT_UM;

    // Next-state logic of the pattern FSM, including preemption and idle return.
    always_comb begin
        estado_prox_s = estado_r;
        cont_prox_s   = cont_r;
        canal_prox_s  = canal_r;
        conclusao_s   = 1'b0;
        preempcao_s   = 1'b0;
        case (estado_r)
            OCIOSO: begin
                cont_prox_s = CONT_ZERO;
                if (algum_s) begin
                    estado_prox_s = LIGADO;
                    canal_prox_s  = sel_s;
                end else begin
                    estado_prox_s = OCIOSO;
                    canal_prox_s  = CANAL_ZERO;
                end
            end
            LIGADO, DESLIGADO: begin
                if (!algum_s) begin
                    estado_prox_s = OCIOSO;
                    cont_prox_s   = CONT_ZERO;
                    canal_prox_s  = CANAL_ZERO;
                end else if (sel_s != canal_r) begin
                    preempcao_s   = 1'b1;
                    estado_prox_s = LIGADO;
                    cont_prox_s   = CONT_ZERO;
                    canal_prox_s  = sel_s;
                end else if (estado_r == LIGADO) begin
                    if (cont_r == LIMITE_ON) begin
                        conclusao_s   = 1'b1;
                        cont_prox_s   = CONT_ZERO;
                        // Channel 0 has no off-phase: restart the on-phase for a continuous tone.
                        estado_prox_s = (canal_r == CANAL_ZERO) ? LIGADO : DESLIGADO;
                    end else begin
                        cont_prox_s = cont_r + CONT_UM;
                    end
                end else begin
                    if (cont_r == limite_off_s) begin
                        cont_prox_s   = CONT_ZERO;
                        estado_prox_s = LIGADO;
                    end else begin
                        cont_prox_s = cont_r + CONT_UM;
                    end
                end
            end
            default: begin
                estado_prox_s = OCIOSO;
                cont_prox_s   = CONT_ZERO;
                canal_prox_s  = CANAL_ZERO;
            end
        endcase
    end

    // Output decode: the buzzer is driven from the next state so the pin is a clean flop output.
    always_comb begin
        sinal_prox_s = (estado_prox_s == LIGADO);
    end

    // FSM state, phase counter, latched channel and buzzer drive.
    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            estado_r <= OCIOSO;
            cont_r   <= CONT_ZERO;
            canal_r  <= CANAL_ZERO;
            sinal_r  <= 1'b0;
        end else begin
            estado_r <= estado_prox_s;
            cont_r   <= cont_prox_s;
            canal_r  <= canal_prox_s;
            sinal_r  <= sinal_prox_s;
        end
    end

`ifdef BUZZER_REPETICOES_EN
    localparam int LARGURA_BIPES = (MAX_BIPES > 1) ? $clog2(MAX_BIPES) : 1;
    localparam logic [LARGURA_BIPES-1:0] BIPES_ZERO  = LARGURA_BIPES'(0);
    localparam logic [LARGURA_BIPES-1:0] BIPES_UM    = LARGURA_BIPES'(1);
    localparam logic [LARGURA_BIPES-1:0] ULTIMO_BIPE = LARGURA_BIPES'(MAX_BIPES - 1);

    logic [LARGURA_BIPES-1:0] bipes_r;
    logic [LARGURA_BIPES-1:0] bipes_prox_s;
    logic                     liga_atual_s;
    logic                     ultimo_s;

    assign liga_atual_s = bus.liga[canal_r];
    assign ultimo_s     = conclusao_s && (bipes_r == ULTIMO_BIPE);

    // Auto-disarm request for the channel finishing its last allowed on-phase.
    always_comb begin
        desarme_s = {CANAIS{1'b0}};
        for (int i = 0; i < CANAIS; i++) begin
            desarme_s[i] = ultimo_s && (canal_r == LARGURA_CANAL'(i));
        end
    end

    // Beep count: restarts on idle, preemption or a fresh arm of the sounding channel.
    always_comb begin
        bipes_prox_s = bipes_r;
        if ((estado_r == OCIOSO) || !algum_s || preempcao_s || liga_atual_s) begin
            bipes_prox_s = BIPES_ZERO;
        end else if (conclusao_s) begin
            bipes_prox_s = ultimo_s ? BIPES_ZERO : (bipes_r + BIPES_UM);
        end else begin
            bipes_prox_s = bipes_r;
        end
    end

    // Beep counter register.
    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            bipes_r <= BIPES_ZERO;
        end else begin
            bipes_r <= bipes_prox_s;
        end
    end
`else
    assign desarme_s = {CANAIS{1'b0}};
`endif

    // Arm flag update: arm beats disarm, disarm beats auto-disarm.
    always_comb begin
        ativo_prox_s = ativo_r;
        for (int i = 0; i < CANAIS; i++) begin
            if (bus.liga[i]) begin
                ativo_prox_s[i] = 1'b1;
            end else if (bus.desliga[i] || desarme_s[i]) begin
                ativo_prox_s[i] = 1'b0;
            end else begin
                ativo_prox_s[i] = ativo_r[i];
            end
        end
    end

    // Arm flags and busy flag move on the same edge.
    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            ativo_r   <= {CANAIS{1'b0}};
            ocupado_r <= 1'b0;
        end else begin
            ativo_r   <= ativo_prox_s;
            ocupado_r <= |ativo_prox_s;
        end
    end

    assign bus.sinal       = sinal_r;
    assign bus.ativo       = ativo_r;
    assign bus.canal_atual = canal_r;
    assign bus.ocupado     = ocupado_r;

endmodule

// File: doc/buzzer_padrao.md
Name: buzzer_padrao

Overview:
- Multi-channel successor to the single-latch buzzer.
- CANAIS independent alarm requests, each armed and disarmed by pulses.
- A fixed-priority arbiter picks the most urgent armed channel. A pattern FSM then drives one buzzer line with that channel's beep pattern.
- Sits between the system control FSM (which raises alarms) and the physical buzzer pin.

Parameters:
- CANAIS, 4, number of alarm channels (1..8); index 0 has the highest priority.
- PERIODO_BASE, 1000, clock cycles of one on-phase; must be >= 1.
- LARGURA_CONT, $clog2(PERIODO_BASE*CANAIS+1), phase counter width; derived, not overridden.
- MAX_BIPES, 3, completed on-phases before auto-disarm; used only with BUZZER_REPETICOES_EN.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- zera_n  in  1  asynchronous active-low reset.
- liga  in  CANAIS  per-channel arm pulse (level-sampled each cycle).
- desliga  in  CANAIS  per-channel disarm pulse.
- sinal  out  1  buzzer drive; registered.
- ativo  out  CANAIS  armed flag per channel; registered.
- canal_atual  out  $clog2(CANAIS) (min 1)  index of the channel being sounded; 0 when idle.
- ocupado  out  1  high while any channel is armed.

Behaviour:
- Reset (zera_n low, asynchronous): clears ativo, sinal, canal_atual and ocupado to 0, clears the phase counter, and puts the FSM in OCIOSO. Reset mid-beep silences sinal immediately, with no wait for a clock edge.
- Arm flags, per channel i, each edge:
  - liga[i]=1 sets ativo[i].
  - Otherwise desliga[i]=1 clears ativo[i].
  - Simultaneous liga and desliga on the same channel: liga wins.
  - Channels are independent; any mix of channels may change in the same cycle.
- Arbitration: the selected channel is the lowest index with ativo=1, computed from the registered ativo.
- Channel i pattern: on-phase of PERIODO_BASE cycles, then off-phase of PERIODO_BASE*i cycles, repeating.
  - Channel 0 has no off-phase, so it produces a continuous tone.
- FSM states:
  - OCIOSO: sinal=0, counter=0. When ativo becomes nonzero: go to LIGADO, counter=0, latch canal_atual.
  - LIGADO: sinal=1, counter increments. When counter reaches PERIODO_BASE-1: counter=0 and go to DESLIGADO. If canal_atual=0, stay in LIGADO and restart the count instead.
  - DESLIGADO: sinal=0, counter increments. When counter reaches PERIODO_BASE*canal_atual-1: counter=0 and go to LIGADO.
- Latency:
  - sinal rises 2 edges after the liga pulse is sampled: edge 1 sets ativo, edge 2 moves the FSM to LIGADO.
  - sinal falls 2 edges after the desliga pulse of the last armed channel is sampled.
- Preemption, from LIGADO or DESLIGADO:
  - If the arbiter's selection differs from canal_atual, then on the next edge: canal_atual = new selection, counter=0, state LIGADO. The new pattern starts fresh, with no partial phase carried over.
  - If ativo becomes all zero: go to OCIOSO on the next edge.
- Outputs:
  - ocupado = |ativo, registered, tracking ativo with the same edge.
  - sinal is a registered function of the next state, so it is glitch-free.
- Widths: the counter is LARGURA_CONT bits. The maximum compare value is PERIODO_BASE*(CANAIS-1)-1, so it never wraps.

Optional Feature:
- Macro BUZZER_REPETICOES_EN.
- When defined:
  - A per-FSM beep counter counts completed on-phases of canal_atual; completion is the LIGADO-to-DESLIGADO transition, or the LIGADO restart for channel 0.
  - On completion number MAX_BIPES, ativo[canal_atual] is cleared on that same edge. The FSM then re-arbitrates on the next edge: to OCIOSO, or to LIGADO for the next armed channel.
  - The beep counter clears on reset, on preemption, and on a new liga of the current channel.
  - liga has priority over auto-disarm in the same cycle, which restarts the count at 0.
- When undefined: channels stay armed until desliga; MAX_BIPES is ignored and no beep counter exists.

Test Plan:
All scenarios use CANAIS=4, PERIODO_BASE=4.
- Reset: zera_n=0 asynchronously during LIGADO -> sinal, ativo, ocupado and canal_atual read 0 before the next edge; release -> FSM in OCIOSO.
- Channel 2 pattern: liga=4'b0100 for 1 cycle -> sinal=1 from edge 2 for 4 cycles, then 0 for 8 cycles, repeating; canal_atual=2, ocupado=1.
- Channel 0 tone: liga=4'b0001 -> sinal=1 continuously with no low cycle; desliga=4'b0001 -> sinal=0 two edges later.
- Preemption: channel 3 in DESLIGADO, then liga=4'b0010 -> next edge canal_atual=1, sinal=1 for 4 cycles, then 0 for 4; desliga=4'b0010 -> returns to the channel 3 pattern from a fresh on-phase.
- Simultaneous events: liga=desliga=4'b0100 in one cycle -> ativo[2]=1. Then desliga=4'b1111 -> ativo=0, FSM in OCIOSO.
- With BUZZER_REPETICOES_EN and MAX_BIPES=3: liga channel 1 -> exactly 3 on-phases of 4 cycles; ativo[1] clears at the end of the 3rd on-phase; sinal stays 0 afterwards.
